// File: rtl/enc16_req_queue.sv
// One-hot request collector: sticky pending set, one binary index per valid/ready transfer.
// Define ENC16_RR_EN for round-robin selection; otherwise the lowest index always wins.
module enc16_req_queue (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req,
    output logic [3:0]  out_code,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_more,
    output logic        dup_req,
    output logic [4:0]  pend_cnt
);

    localparam int unsigned NREQ   = 16;
    localparam int unsigned CODE_W = 4;
    localparam int unsigned CNT_W  = 5;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]        state, state_nxt;
    logic [NREQ-1:0]   pending, pending_nxt;
    logic [CODE_W-1:0] code_nxt;
    logic              valid_nxt;
    logic              more_nxt;
    logic              dup_nxt;
    logic [CNT_W-1:0]  cnt_nxt;

    logic [NREQ-1:0]   cand;
    logic [NREQ-1:0]   presented;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   search;
    logic [CODE_W-1:0] offset;
    logic [CODE_W-1:0] sel;
    logic              load;

`ifdef ENC16_RR_EN
    logic [CODE_W-1:0] rr_ptr, rr_ptr_nxt;
    logic [2*NREQ-1:0] rot_dbl;
`endif

    function automatic logic [CNT_W-1:0] popcount(input logic [NREQ-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    // Candidate set and index selection (search vector rotated by rr_ptr in RR mode)
    always_comb begin
        cand      = pending | req;
        presented = out_valid ? (NREQ'(1) << out_code) : '0;
`ifdef ENC16_RR_EN
        rot_dbl   = {cand, cand} >> rr_ptr;
        search    = rot_dbl[NREQ-1:0];
`else
        search    = cand;
`endif
        offset = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (search[i]) begin
                offset = CODE_W'(i);
            end
        end
`ifdef ENC16_RR_EN
        sel = offset + rr_ptr;
`else
        sel = offset;
`endif
    end

    // Next-state and registered-output logic
    always_comb begin
        state_nxt = state;
        code_nxt  = out_code;
        valid_nxt = out_valid;
        more_nxt  = out_more;
        grant     = '0;
        load      = 1'b0;

        case (state)
            ST_IDLE: begin
                valid_nxt = 1'b0;
                if (|cand) begin
                    load = 1'b1;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    if (|cand) begin
                        load = 1'b1;
                    end else begin
                        valid_nxt = 1'b0;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                valid_nxt = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase

        if (load) begin
            grant     = NREQ'(1) << sel;
            code_nxt  = sel;
            valid_nxt = 1'b1;
            more_nxt  = |(cand & ~grant);
            state_nxt = ST_HOLD;
        end

        pending_nxt = cand & ~grant;
        dup_nxt     = |(req & (pending | presented));
        cnt_nxt     = popcount(pending_nxt);
`ifdef ENC16_RR_EN
        rr_ptr_nxt  = load ? sel + CODE_W'(1) : rr_ptr;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            pending   <= '0;
            out_code  <= '0;
            out_valid <= 1'b0;
            out_more  <= 1'b0;
            dup_req   <= 1'b0;
            pend_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            pending   <= pending_nxt;
            out_code  <= code_nxt;
            out_valid <= valid_nxt;
            out_more  <= more_nxt;
            dup_req   <= dup_nxt;
            pend_cnt  <= cnt_nxt;
        end
    end

`ifdef ENC16_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else begin
            rr_ptr <= rr_ptr_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_enc16_req_queue.sv
// Directed bench for enc16_req_queue; expected transfers are queued when requests are driven.
module tb_enc16_req_queue;

    typedef struct packed {
        logic [3:0] code;
        logic       more;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req;
    logic [3:0]  out_code;
    logic        out_valid;
    logic        out_ready;
    logic        out_more;
    logic        dup_req;
    logic [4:0]  pend_cnt;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    enc16_req_queue dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .out_code  (out_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_more  (out_more),
        .dup_req   (dup_req),
        .pend_cnt  (pend_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] code, input logic more);
        exp_t e;
        e.code = code;
        e.more = more;
        sb.push_back(e);
    endtask

    // Score any transfer happening at the coming edge, then advance to 1 time unit after it
    task automatic tick();
        exp_t e;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL xfer_unexpected observed=code %0d expected=no transfer", out_code);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("xfer_code", 32'(out_code), 32'(e.code));
                chk("xfer_more", 32'(out_more), 32'(e.more));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_code"},  32'(out_code),  32'd0);
        chk({tag, "_more"},  32'(out_more),  32'd0);
        chk({tag, "_dup"},   32'(dup_req),   32'd0);
        chk({tag, "_cnt"},   32'(pend_cnt),  32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        req       = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        rst = 1'b0;
        tick();

        // single request, one-cycle latency, then drain
        req = 16'h0001;
        push(4'd0, 1'b0);
        tick();
        req = '0;
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_code",  32'(out_code),  32'd0);
        chk("t1_more",  32'(out_more),  32'd0);
        out_ready = 1'b1;
        tick();
        chk("t1_valid_drop", 32'(out_valid), 32'd0);

        // three requests served back-to-back in priority order
        req = 16'h8005;
        push(4'd0, 1'b1);
        push(4'd2, 1'b1);
        push(4'd15, 1'b0);
        tick();
        req = '0;
        chk("t2_cnt0", 32'(pend_cnt), 32'd2);
        tick();
        chk("t2_code1", 32'(out_code), 32'd2);
        chk("t2_cnt1",  32'(pend_cnt), 32'd1);
        tick();
        chk("t2_code2", 32'(out_code), 32'd15);
        chk("t2_cnt2",  32'(pend_cnt), 32'd0);
        tick();
        chk("t2_valid_drop", 32'(out_valid), 32'd0);

        // stall: presented code held while a new request is queued
        out_ready = 1'b0;
        req = 16'h0008;
        push(4'd3, 1'b0);
        tick();
        req = 16'h0010;
        push(4'd4, 1'b0);
        tick();
        req = '0;
        for (int i = 0; i < 4; i++) begin
            chk("t3_code_hold", 32'(out_code), 32'd3);
            chk("t3_cnt_hold",  32'(pend_cnt), 32'd1);
            tick();
        end
        chk("t3_more_hold", 32'(out_more), 32'd0);
        out_ready = 1'b1;
        tick();
        chk("t3_code_next", 32'(out_code), 32'd4);
        chk("t3_cnt_next",  32'(pend_cnt), 32'd0);
        tick();
        chk("t3_valid_drop", 32'(out_valid), 32'd0);

        // re-request of the presented index during transfer
        out_ready = 1'b0;
        req = 16'h0080;
        push(4'd7, 1'b0);
        tick();
        req = '0;
        chk("t4_code", 32'(out_code), 32'd7);
        chk("t4_dup_quiet", 32'(dup_req), 32'd0);
        out_ready = 1'b1;
        req = 16'h0080;
        push(4'd7, 1'b0);
        tick();
        req = '0;
        chk("t4_dup", 32'(dup_req), 32'd1);
        chk("t4_valid_re", 32'(out_valid), 32'd1);
        chk("t4_code_re", 32'(out_code), 32'd7);
        tick();
        chk("t4_dup_end", 32'(dup_req), 32'd0);
        chk("t4_valid_drop", 32'(out_valid), 32'd0);

        // fill all 16, then asynchronous reset mid-hold
        out_ready = 1'b0;
        req = 16'hFFFF;
        tick();
        chk("t5_code", 32'(out_code), 32'd0);
        chk("t5_cnt15", 32'(pend_cnt), 32'd15);
        req = 16'h0001;
        tick();
        req = '0;
        chk("t5_cnt16", 32'(pend_cnt), 32'd16);
        chk("t5_dup", 32'(dup_req), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_idle_outputs("t5_async");
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("t5_no_code", 32'(out_valid), 32'd0);
        chk("t5_cnt_clr", 32'(pend_cnt), 32'd0);

        // all requests held: fixed priority repeats 0, round-robin walks and wraps
        req = 16'hFFFF;
        for (int i = 0; i < 17; i++) begin
`ifdef ENC16_RR_EN
            push(4'(i % 16), 1'b1);
`else
            push(4'd0, 1'b1);
`endif
        end
        for (int i = 0; i < 18; i++) begin
            tick();
        end
        req = '0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
